// File: rtl/gelato_warp_issue_scheduler.sv
// gelato_warp_issue_scheduler: per-warp hazard-checked issue selection with an integrated scoreboard
module gelato_warp_issue_scheduler #(
    parameter int WARP_NUM = 8,
    parameter int SB_DEPTH = 4,
    parameter int REG_W    = 5,
    parameter int INST_W   = 32,
    parameter int WID_W    = $clog2(WARP_NUM)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       policy,
    input  logic [WARP_NUM-1:0]        ibuf_valid,
    input  logic [WARP_NUM*INST_W-1:0] ibuf_inst,
    input  logic [WARP_NUM*REG_W-1:0]  ibuf_rd,
    input  logic [WARP_NUM*REG_W-1:0]  ibuf_rs1,
    input  logic [WARP_NUM*REG_W-1:0]  ibuf_rs2,
    output logic [WARP_NUM-1:0]        ibuf_pop,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [INST_W-1:0]          issue_inst,
    output logic [WID_W-1:0]           issue_warp,
    input  logic                       wb_valid,
    input  logic [WID_W-1:0]           wb_warp,
    input  logic [REG_W-1:0]           wb_rd,
    output logic                       sb_err
);
    localparam int SB_W = SB_DEPTH > 1 ? $clog2(SB_DEPTH) : 1;

    logic [SB_DEPTH-1:0] sb_v [WARP_NUM];
    logic [REG_W-1:0]    sb_r [WARP_NUM][SB_DEPTH];
    logic [WID_W-1:0]    last_warp, sel, idx;
    logic [WARP_NUM-1:0] elig, hazard, full;
    logic [REG_W-1:0]    sel_rd, rd, rs1, rs2;
    logic [SB_W-1:0]     alloc_idx, wb_idx;
    logic                load, found, wb_hit;

    // hazard/full/eligibility per warp, from registered scoreboard state only
    always_comb begin
        hazard = '0;
        full   = '0;
        elig   = '0;
        rd     = '0;
        rs1    = '0;
        rs2    = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            rd      = ibuf_rd[w*REG_W +: REG_W];
            rs1     = ibuf_rs1[w*REG_W +: REG_W];
            rs2     = ibuf_rs2[w*REG_W +: REG_W];
            full[w] = &sb_v[w];
            for (int e = 0; e < SB_DEPTH; e++)
                if (sb_v[w][e] && sb_r[w][e] != '0 && (sb_r[w][e] == rs1 || sb_r[w][e] == rs2 || sb_r[w][e] == rd))
                    hazard[w] = 1'b1;
            elig[w] = ibuf_valid[w] && !hazard[w] && (rd == '0 || !full[w]);
        end
    end

    // warp selection, load decision, pop pulse and scoreboard slot lookup
    always_comb begin
        sel   = last_warp;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= WARP_NUM; i++) begin
            idx = last_warp + WID_W'(i);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        if (policy && elig[last_warp])
            sel = last_warp;
        load      = rdy && (!issue_valid || issue_ready) && |elig;
        ibuf_pop  = (load && rst_n) ? (WARP_NUM'(1) << sel) : '0;
        sel_rd    = ibuf_rd[int'(sel)*REG_W +: REG_W];
        alloc_idx = '0;
        wb_idx    = '0;
        wb_hit    = 1'b0;
        for (int e = SB_DEPTH - 1; e >= 0; e--) begin
            if (!sb_v[sel][e])
                alloc_idx = SB_W'(e);
            if (sb_v[wb_warp][e] && sb_r[wb_warp][e] == wb_rd) begin
                wb_idx = SB_W'(e);
                wb_hit = 1'b1;
            end
        end
    end

    // issue register, scoreboard release/allocate (allocate wins on a shared slot) and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            issue_inst  <= '0;
            issue_warp  <= '0;
            sb_err      <= 1'b0;
            last_warp   <= '1;
            for (int w = 0; w < WARP_NUM; w++) begin
                sb_v[w] <= '0;
                for (int e = 0; e < SB_DEPTH; e++)
                    sb_r[w][e] <= '0;
            end
        end else begin
            if (wb_valid) begin
                if (wb_hit && wb_rd != '0)
                    sb_v[wb_warp][wb_idx] <= 1'b0;
                else
                    sb_err <= 1'b1;
            end
            if (load) begin
                issue_valid <= 1'b1;
                issue_inst  <= ibuf_inst[int'(sel)*INST_W +: INST_W];
                issue_warp  <= sel;
                last_warp   <= sel;
                if (sel_rd != '0) begin
                    sb_v[sel][alloc_idx] <= 1'b1;
                    sb_r[sel][alloc_idx] <= sel_rd;
                end
            end else if (rdy && issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end
endmodule
